// File: rtl/stat_digit_renderer_if.sv
// Conversion request channel of the stat digit renderer: load/value in, busy/done out.
// load has no ready: every load is accepted, either starting a conversion or (while busy) replacing the pending value.
interface stat_digit_renderer_if #(
  parameter int VALUE_W = 16
);
  logic               load;
  logic [VALUE_W-1:0] value;
  logic               busy;
  logic               done;

  modport master (output load, value, input busy, done);
  modport slave  (input load, value, output busy, done);
endinterface

// File: rtl/stat_digit_renderer.sv
// Binary stat value -> right-aligned blanked decimal glyph codes via sequential double-dabble,
// plus the per-pixel font ROM addressing and registered pixel_on for the status panel.
module stat_digit_renderer #(
  parameter int NUM_DIGITS = 5,
  parameter int VALUE_W    = 16
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  stat_digit_renderer_if.slave    conv,
  input  logic [9:0]              RegionX,
  input  logic [9:0]              RegionY,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  output logic [7:0]              font_addr,
  input  logic [7:0]              font_data,
  output logic                    pixel_on,
  output logic [1:0]              state_dbg,
  output logic [4*NUM_DIGITS-1:0] codes_dbg
);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(VALUE_W);
  localparam logic [63:0] MAX_VAL = 64'(10**NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t             state;
  logic               busy_q;
  logic               done_q;
  logic               pending;
  logic [VALUE_W-1:0] pend_val;
  logic [VALUE_W-1:0] bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_W-1:0]   codes_q;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shift;
  logic [VALUE_W-1:0] bin_shift;
  logic [BCD_W-1:0]   new_codes;
  logic               seen;
  logic [3:0]         digit;

  // Saturate so the result always fits the field; compared at 64 bits so wide fields never truncate.
  function automatic logic [VALUE_W-1:0] sat(input logic [VALUE_W-1:0] v);
    if (64'(v) > MAX_VAL) return MAX_VAL[VALUE_W-1:0];
    return v;
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {bcd_shift, bin_shift} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
  end

  // Leading-zero blanking from slot 0 (most significant); the last slot always shows a digit.
  always_comb begin
    seen      = 1'b0;
    digit     = 4'd0;
    new_codes = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit = bcd_q[4*(NUM_DIGITS-1-i) +: 4];
      seen  = seen | (digit != 4'd0) | (i == NUM_DIGITS - 1);
      new_codes[4*(NUM_DIGITS-1-i) +: 4] = seen ? digit + 4'd1 : 4'd0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pending  <= 1'b0;
      pend_val <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt      <= '0;
      codes_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (conv.load) begin
            bin_q  <= sat(conv.value);
            bcd_q  <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          bcd_q <= bcd_shift;
          bin_q <= bin_shift;
          cnt   <= cnt + CNT_W'(1);
          if (conv.load) begin
            pending  <= 1'b1;
            pend_val <= conv.value;
          end
          if (cnt == CNT_W'(VALUE_W - 1)) state <= COMMIT;
        end
        COMMIT: begin
          codes_q <= new_codes;
          done_q  <= 1'b1;
          // A load landing on the commit cycle is newer than any pending value.
          if (conv.load || pending) begin
            bin_q   <= sat(conv.load ? conv.value : pend_val);
            bcd_q   <= '0;
            cnt     <= '0;
            pending <= 1'b0;
            state   <= CONV;
          end else begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign conv.busy = busy_q;
  assign conv.done = done_q;
  assign state_dbg = state;
  assign codes_dbg = codes_q;

  logic [9:0] rel_x;
  logic [9:0] rel_y;
  logic       in_region;
  logic [6:0] slot;
  logic [2:0] col;
  logic [3:0] slot_code;

  // The DrawX>=RegionX / DrawY>=RegionY terms stop wrapped differences from aliasing into the field.
  assign rel_x     = DrawX - RegionX;
  assign rel_y     = DrawY - RegionY;
  assign in_region = (DrawX >= RegionX) && (rel_x < 10'(8 * NUM_DIGITS)) &&
                     (DrawY >= RegionY) && (rel_y < 10'd16);
  assign slot      = rel_x[9:3];
  assign col       = rel_x[2:0];

  always_comb begin
    slot_code = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot == 7'(i)) slot_code = codes_q[4*(NUM_DIGITS-1-i) +: 4];
    end
  end

  assign font_addr = in_region ? {slot_code, rel_y[3:0]} : 8'h00;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) pixel_on <= 1'b0;
    else          pixel_on <= in_region & font_data[3'd7 - col];
  end
endmodule

// File: tb/tb_stat_digit_renderer.sv
// Bench for stat_digit_renderer: decimal/timing model per cycle, directed cases, randomized loads and pixels.
module tb_stat_digit_renderer;
  localparam int ND  = 5;
  localparam int ND4 = 4;
  localparam int VW  = 16;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  stat_digit_renderer_if #(.VALUE_W(VW)) conv ();
  stat_digit_renderer_if #(.VALUE_W(VW)) conv4 ();

  logic [9:0]      RegionX, RegionY, DrawX, DrawY;
  logic [7:0]      font_addr, font_data, font_addr4, font_data4;
  logic            pixel_on, pixel_on4;
  logic [1:0]      state_dbg, state_dbg4;
  logic [4*ND-1:0] codes_dbg;
  logic [4*ND4-1:0] codes_dbg4;

  stat_digit_renderer #(.NUM_DIGITS(ND), .VALUE_W(VW)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .conv(conv),
    .RegionX(RegionX), .RegionY(RegionY), .DrawX(DrawX), .DrawY(DrawY),
    .font_addr(font_addr), .font_data(font_data), .pixel_on(pixel_on),
    .state_dbg(state_dbg), .codes_dbg(codes_dbg)
  );

  stat_digit_renderer #(.NUM_DIGITS(ND4), .VALUE_W(VW)) u_dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .conv(conv4),
    .RegionX(RegionX), .RegionY(RegionY), .DrawX(DrawX), .DrawY(DrawY),
    .font_addr(font_addr4), .font_data(font_data4), .pixel_on(pixel_on4),
    .state_dbg(state_dbg4), .codes_dbg(codes_dbg4)
  );

  // Font ROM stand-in: blank glyph for code 0, 0x82 pinned so bit 6 is set and bit 0 clear.
  function automatic logic [7:0] rom(input logic [7:0] a);
    if (a[7:4] == 4'd0) return 8'h00;
    if (a == 8'h82) return 8'h7C;
    return 8'(a * 8'd29 + 8'd17) ^ {a[3:0], a[7:4]};
  endfunction

  assign font_data  = rom(font_addr);
  assign font_data4 = rom(font_addr4);

  // ---------------- reference model ----------------
  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] render(input int unsigned v, input int nd);
    int unsigned s, maxv, d;
    logic [19:0] r;
    bit seen;
    maxv = 10**nd - 1;
    s = (v > maxv) ? maxv : v;
    r = '0;
    seen = 1'b0;
    for (int i = 0; i < nd; i++) begin
      d = (s / (10**(nd-1-i))) % 10;
      if (d != 0 || i == nd - 1) seen = 1'b1;
      r[4*(nd-1-i) +: 4] = seen ? 4'(d + 1) : 4'd0;
    end
    return r;
  endfunction

  function automatic logic [7:0] m_addr(input logic [9:0] dx, input logic [9:0] dy,
                                        input logic [4*ND-1:0] codes, output bit inr, output int col);
    int rx, ry, slot;
    logic [4*ND-1:0] c;
    rx  = int'(dx) - int'(RegionX);
    ry  = int'(dy) - int'(RegionY);
    inr = (rx >= 0) && (rx < 8*ND) && (ry >= 0) && (ry < 16);
    col = rx & 7;
    if (!inr) return 8'h00;
    slot = rx / 8;
    c = codes >> (4*(ND-1-slot));
    return {c[3:0], 4'(ry)};
  endfunction

  logic [4*ND-1:0] m_codes = '0;
  bit              m_done = 1'b0, m_busy = 1'b0, m_pix = 1'b0;
  bit              job_active = 1'b0, pend_v = 1'b0;
  int unsigned     job_val = 0, job_end = 0, pend_val = 0, cyc = 0;
  logic [4*ND-1:0] exp_q[$];

  always @(posedge Clk or negedge Reset_n) begin
    bit inr;
    int col;
    logic [7:0] a, d;
    if (!Reset_n) begin
      m_codes = '0; m_done = 0; m_busy = 0; m_pix = 0;
      job_active = 0; pend_v = 0;
      exp_q.delete();
    end else begin
      cyc++;
      a = m_addr(DrawX, DrawY, m_codes, inr, col);
      d = rom(a);
      m_pix = inr && d[7-col];
      m_done = 0;
      if (job_active && cyc == job_end) begin
        m_codes = render(job_val, ND);
        m_done = 1;
        exp_q.push_back(m_codes);
        if (conv.load) begin job_val = conv.value; job_end = cyc + VW + 1; end
        else if (pend_v) begin job_val = pend_val; job_end = cyc + VW + 1; end
        else job_active = 0;
        pend_v = 0;
      end else if (job_active) begin
        if (conv.load) begin pend_v = 1; pend_val = conv.value; end
      end else if (conv.load) begin
        job_active = 1; job_val = conv.value; job_end = cyc + VW + 1;
      end
      m_busy = job_active;
    end
  end

  // ---------------- scoreboard / per-cycle compare ----------------
  always @(negedge Clk) begin
    bit inr;
    int col;
    logic [7:0] a;
    if (checking) begin
      a = m_addr(DrawX, DrawY, m_codes, inr, col);
      chk("busy", 32'(conv.busy), 32'(m_busy));
      chk("done", 32'(conv.done), 32'(m_done));
      chk("codes", 32'(codes_dbg), 32'(m_codes));
      chk("font_addr", 32'(font_addr), 32'(a));
      chk("pixel_on", 32'(pixel_on), 32'(m_pix));
      if (conv.done) begin
        done_cnt++;
        if (exp_q.size() == 0) chk("commit_unexpected", 32'(codes_dbg), 32'hFFFFFFFF);
        else chk("commit", 32'(codes_dbg), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_load(input logic [VW-1:0] v);
    conv.load = 1'b1;
    conv.value = v;
    tick();
    conv.load = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (conv.busy && n < budget) begin tick(); n++; end
    if (conv.busy) chk("wait_idle_timeout", 32'(conv.busy), 32'd0);
  endtask

  task automatic load4(input logic [VW-1:0] v, input logic [15:0] exp_codes);
    conv4.load = 1'b1;
    conv4.value = v;
    tick();
    conv4.load = 1'b0;
    repeat (VW) tick();
    chk("d4_done_early", 32'(conv4.done), 32'd0);
    tick();
    chk("d4_done", 32'(conv4.done), 32'd1);
    chk("d4_codes", 32'(codes_dbg4), 32'(exp_codes));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0;
    conv.load = 0; conv.value = '0; conv4.load = 0; conv4.value = '0;
    RegionX = 10'd100; RegionY = 10'd50; DrawX = '0; DrawY = '0;
    tick(); tick();
    checking = 1'b1;
    tick();
    Reset_n = 1'b1;
    chk("rst_busy", 32'(conv.busy), 32'd0);
    chk("rst_codes", 32'(codes_dbg), 32'd0);
    chk("rst_codes4", 32'(codes_dbg4), 32'd0);
    chk("rst_pix", 32'(pixel_on), 32'd0);
    tick();

    // 1234: busy 17 cycles, single done
    d0 = done_cnt;
    pulse_load(16'd1234);
    wait_idle(100, n);
    chk("busy_cycles", 32'(n), 32'd17);
    chk("done_at_end", 32'(conv.done), 32'd1);
    chk("codes_1234", 32'(codes_dbg), 32'h02345);
    tick();
    chk("done_once", 32'(done_cnt - d0), 32'd1);

    pulse_load(16'd0);
    wait_idle(100, n);
    chk("codes_0", 32'(codes_dbg), 32'h00001);
    pulse_load(16'd65535);
    wait_idle(100, n);
    chk("codes_65535", 32'(codes_dbg), 32'h76646);

    // four-digit instance: saturation boundary
    load4(16'd65535, 16'hAAAA);
    load4(16'd1000,  16'h2111);
    load4(16'd10000, 16'hAAAA);
    load4(16'd0,     16'h0001);
    load4(16'd9999,  16'hAAAA);

    // pixel path
    pulse_load(16'd7);
    wait_idle(100, n);
    DrawX = 10'd133; DrawY = 10'd52; #1;
    chk("addr_133_52", 32'(font_addr), 32'h82);
    tick();
    chk("pix_133_52", 32'(pixel_on), 32'd1);
    DrawX = 10'd139; tick();
    chk("pix_139_52", 32'(pixel_on), 32'd0);
    DrawX = 10'd99; #1;
    chk("addr_99", 32'(font_addr), 32'h00);
    tick();
    chk("pix_99", 32'(pixel_on), 32'd0);
    DrawX = 10'd133; DrawY = 10'd66; #1;
    chk("addr_y66", 32'(font_addr), 32'h00);
    tick();
    chk("pix_y66", 32'(pixel_on), 32'd0);

    // last pending value wins
    d0 = done_cnt;
    pulse_load(16'd100);
    repeat (3) tick();
    pulse_load(16'd200);
    repeat (3) tick();
    pulse_load(16'd300);
    wait_idle(100, n);
    tick();
    chk("pending_dones", 32'(done_cnt - d0), 32'd2);
    chk("codes_300", 32'(codes_dbg), 32'h00411);

    // load on the commit cycle with nothing pending
    pulse_load(16'd55);
    repeat (16) tick();
    conv.load = 1'b1; conv.value = 16'd4096;
    tick();
    conv.load = 1'b0;
    chk("commit_load_done", 32'(conv.done), 32'd1);
    chk("commit_load_busy", 32'(conv.busy), 32'd1);
    chk("codes_55", 32'(codes_dbg), 32'h00066);
    wait_idle(100, n);
    chk("codes_4096", 32'(codes_dbg), 32'h051A7);

    // reset mid-conversion
    tick();
    d0 = done_cnt;
    pulse_load(16'd4321);
    repeat (5) tick();
    Reset_n = 1'b0; #1;
    chk("midrst_busy", 32'(conv.busy), 32'd0);
    chk("midrst_codes", 32'(codes_dbg), 32'd0);
    repeat (2) tick();
    Reset_n = 1'b1;
    repeat (20) tick();
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    pulse_load(16'd4321);
    wait_idle(100, n);
    chk("codes_4321", 32'(codes_dbg), 32'h05432);

    // randomized loads, pixels and occasional resets; second half uses a field near the wrap point
    for (int k = 0; k < 1200; k++) begin
      if (k == 600) begin RegionX = 10'd1000; RegionY = 10'd1010; end
      conv.load = ($urandom_range(0, 6) == 0);
      case ($urandom_range(0, 3))
        0: conv.value = 16'($urandom_range(0, 9));
        1: conv.value = 16'($urandom_range(0, 999));
        2: conv.value = 16'($urandom);
        default: conv.value = 16'hFFFF - 16'($urandom_range(0, 2));
      endcase
      if ($urandom_range(0, 4) == 0) begin
        DrawX = 10'($urandom); DrawY = 10'($urandom);
      end else begin
        DrawX = 10'(int'(RegionX) + int'($urandom_range(0, 60)) - 8);
        DrawY = 10'(int'(RegionY) + int'($urandom_range(0, 22)) - 3);
      end
      Reset_n = ($urandom_range(0, 399) != 0);
      tick();
    end
    conv.load = 1'b0;
    Reset_n = 1'b1;
    tick();
    wait_idle(200, n);
    tick();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
